// File: rtl/soft_oser16_tx.sv
// soft_oser16_tx -- soft-logic WIDTH:1 serializer with a generated word clock.
//
// Parallel words enter through a one-deep holding register on a valid/ready
// handshake. They are shifted out one bit per clk cycle. A bit counter slices
// the serial stream into frames of WIDTH slots. pclk_o and frame_o mark those
// frames for the receiving deserializer. When no word is waiting at a frame
// boundary, IDLE_WORD is sent instead. Once user data has started flowing,
// this is flagged as an underrun.
//
// Ports:
//   clk            in   fast serial bit clock, rising edge
//   rst_i          in   asynchronous active-low reset
//   data_i         in   parallel word to transmit (WIDTH bits)
//   valid_i        in   data_i is valid
//   ready_o        out  holding register empty; accept = valid_i && ready_o
//   clr_underrun_i in   synchronous clear of underrun_o
//   q_o            out  serial data, registered
//   pclk_o         out  word clock, high for slots 0..WIDTH/2-1
//   frame_o        out  high during slot 0 of every frame
//   underrun_o     out  sticky: frame boundary passed with no word pending
module soft_oser16_tx #(
    parameter int               WIDTH     = 16,
    parameter bit               LSB_FIRST = 1'b1,
    parameter logic [WIDTH-1:0] IDLE_WORD = '0
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             clr_underrun_i,
    output logic             q_o,
    output logic             pclk_o,
    output logic             frame_o,
    output logic             underrun_o
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  CNT_HALF = CW'(WIDTH / 2);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             armed_q, armed_d;
    logic             underrun_q, underrun_d;
    logic             pclk_q, pclk_d;
    logic             frame_q, frame_d;

    logic boundary;
    logic accept;

    always_comb begin
        boundary = (cnt_q == CNT_LAST);
        accept   = valid_i && !hold_full_q;

        // Explicit wrap so non-power-of-two widths also cycle 0..WIDTH-1.
        cnt_d   = boundary ? '0 : cnt_q + CW'(1);
        pclk_d  = (cnt_d < CNT_HALF);
        frame_d = (cnt_d == '0);

        if (boundary) begin
            sh_d = hold_full_q ? hold_q : IDLE_WORD;
        end else if (LSB_FIRST) begin
            sh_d = sh_q >> 1;
        end else begin
            sh_d = sh_q << 1;
        end

        // An accept can never coincide with a transfer because ready_o is low
        // whenever the holding register is full, so no bypass path is needed.
        hold_d      = accept ? data_i : hold_q;
        hold_full_d = (hold_full_q && !boundary) || accept;
        armed_d     = armed_q || accept;

        // Set takes priority over clear when both happen in one cycle.
        if (boundary && !hold_full_q && armed_q) begin
            underrun_d = 1'b1;
        end else if (clr_underrun_i) begin
            underrun_d = 1'b0;
        end else begin
            underrun_d = underrun_q;
        end
    end

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q       <= '0;
            sh_q        <= IDLE_WORD;
            hold_full_q <= 1'b0;
            armed_q     <= 1'b0;
            underrun_q  <= 1'b0;
            pclk_q      <= 1'b1;
            frame_q     <= 1'b1;
        end else begin
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            hold_full_q <= hold_full_d;
            armed_q     <= armed_d;
            underrun_q  <= underrun_d;
            pclk_q      <= pclk_d;
            frame_q     <= frame_d;
        end
    end

    // Holding data is qualified by hold_full_q, so it needs no reset.
    always_ff @(posedge clk) begin
        hold_q <= hold_d;
    end

    assign ready_o    = !hold_full_q;
    assign q_o        = LSB_FIRST ? sh_q[0] : sh_q[WIDTH-1];
    assign pclk_o     = pclk_q;
    assign frame_o    = frame_q;
    assign underrun_o = underrun_q;

endmodule

// File: tb/tb_soft_oser16_tx.sv
// Bench for soft_oser16_tx. Two instances are exercised side by side:
//   index 0: WIDTH=16, LSB_FIRST=1, IDLE_WORD=16'h0000
//   index 1: WIDTH=8,  LSB_FIRST=0, IDLE_WORD=8'h55
// The reference tracks the frame word currently on the wire and the pending
// word. The expected serial bit is simply "bit <slot> of the frame word" in
// transmit order.
module tb_soft_oser16_tx;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        clr = 1'b0;
    logic [1:0]  valid = 2'b00;
    logic [15:0] data16 = '0;
    logic [7:0]  data8 = '0;
    logic [1:0]  dq, dready, dpclk, dframe, dunder;

    int vectors = 0;
    int fails = 0;
    bit run = 1'b0;

    always #5 clk = ~clk;

    soft_oser16_tx #(.WIDTH(16), .LSB_FIRST(1'b1), .IDLE_WORD(16'h0000)) dut16 (
        .clk(clk), .rst_i(rst_i), .data_i(data16), .valid_i(valid[0]),
        .ready_o(dready[0]), .clr_underrun_i(clr), .q_o(dq[0]),
        .pclk_o(dpclk[0]), .frame_o(dframe[0]), .underrun_o(dunder[0]));

    soft_oser16_tx #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_WORD(8'h55)) dut8 (
        .clk(clk), .rst_i(rst_i), .data_i(data8), .valid_i(valid[1]),
        .ready_o(dready[1]), .clr_underrun_i(clr), .q_o(dq[1]),
        .pclk_o(dpclk[1]), .frame_o(dframe[1]), .underrun_o(dunder[1]));

    function automatic int wof(int i);
        return (i == 0) ? 16 : 8;
    endfunction

    function automatic bit lsbof(int i);
        return (i == 0);
    endfunction

    function automatic logic [31:0] idleof(int i);
        return (i == 0) ? 32'h0000_0000 : 32'h0000_0055;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference ----------------
    int          m_cnt[2];
    logic [31:0] m_word[2];
    logic [31:0] m_pword[2];
    bit          m_pend[2];
    bit          m_armed[2];
    bit          m_under[2];
    bit          m_acc[2];

    function automatic logic [31:0] din(int i);
        return (i == 0) ? {16'h0, data16} : {24'h0, data8};
    endfunction

    always @(posedge clk or negedge rst_i) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_i) begin
                m_cnt[i]   <= 0;
                m_word[i]  <= idleof(i);
                m_pword[i] <= '0;
                m_pend[i]  <= 1'b0;
                m_armed[i] <= 1'b0;
                m_under[i] <= 1'b0;
                m_acc[i]   <= 1'b0;
            end else begin
                m_acc[i] <= valid[i] && !m_pend[i];
                m_cnt[i] <= (m_cnt[i] + 1) % wof(i);
                if (m_cnt[i] == wof(i) - 1) begin
                    m_word[i] <= m_pend[i] ? m_pword[i] : idleof(i);
                    m_pend[i] <= valid[i] && !m_pend[i];
                end else begin
                    m_pend[i] <= m_pend[i] || valid[i];
                end
                if (valid[i] && !m_pend[i]) begin
                    m_pword[i] <= din(i);
                    m_armed[i] <= 1'b1;
                end
                if (m_cnt[i] == wof(i) - 1 && !m_pend[i] && m_armed[i])
                    m_under[i] <= 1'b1;
                else if (clr)
                    m_under[i] <= 1'b0;
            end
        end
    end

    function automatic logic exp_q(int i);
        return lsbof(i) ? m_word[i][m_cnt[i]] : m_word[i][wof(i) - 1 - m_cnt[i]];
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (run) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("q[%0d]", i), {31'h0, dq[i]}, {31'h0, exp_q(i)});
                check($sformatf("pclk[%0d]", i), {31'h0, dpclk[i]}, {31'h0, m_cnt[i] < wof(i) / 2});
                check($sformatf("frame[%0d]", i), {31'h0, dframe[i]}, {31'h0, m_cnt[i] == 0});
                check($sformatf("ready[%0d]", i), {31'h0, dready[i]}, {31'h0, !m_pend[i]});
                check($sformatf("underrun[%0d]", i), {31'h0, dunder[i]}, {31'h0, m_under[i]});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_cnt(input int i, input int v);
        int g = 0;
        while (m_cnt[i] != v && g < 100) begin
            @(negedge clk);
            g++;
        end
        check($sformatf("wait_slot[%0d]", i), m_cnt[i], v);
    endtask

    // Samples one full frame starting at the next slot-0 negedge.
    task automatic capture(input int i, output logic [31:0] bits, output logic [31:0] pb);
        bits = '0;
        pb = '0;
        wait_cnt(i, 0);
        for (int s = 0; s < wof(i); s++) begin
            if (s > 0) @(negedge clk);
            bits[s] = dq[i];
            pb[s]   = dpclk[i];
        end
    endtask

    logic [31:0] bits, pb;
    logic [15:0] stream[3];

    initial begin
        stream[0] = 16'h0001;
        stream[1] = 16'h8000;
        stream[2] = 16'hFFFF;

        // Reset state, both instances
        #1 rst_i = 1'b0;
        @(negedge clk);
        run = 1'b1;
        check("rst_q16", {31'h0, dq[0]}, 32'h0);
        check("rst_q8", {31'h0, dq[1]}, 32'h0);
        check("rst_ready", {30'h0, dready}, 32'h3);
        check("rst_pclk", {30'h0, dpclk}, 32'h3);
        check("rst_frame", {30'h0, dframe}, 32'h3);
        check("rst_underrun", {30'h0, dunder}, 32'h0);
        @(negedge clk);
        rst_i = 1'b1;

        // First frame after release: all zeros, no underrun
        capture(0, bits, pb);
        check("post_rst_frame16", bits, 32'h0);
        check("pclk16_pattern", pb, 32'h0000_00FF);
        check("post_rst_underrun16", {31'h0, dunder[0]}, 32'h0);

        // Single LSB-first word accepted at slot 2
        wait_cnt(0, 2);
        data16 = 16'hA5C3;
        valid[0] = 1'b1;
        @(negedge clk);
        valid[0] = 1'b0;
        capture(0, bits, pb);
        check("word_A5C3", bits, 32'h0000_A5C3);
        @(negedge clk);
        check("underrun_after_A5C3", {31'h0, dunder[0]}, 32'h1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("underrun_cleared", {31'h0, dunder[0]}, 32'h0);

        // Boundary accept on the WIDTH=8 MSB-first instance, never armed
        wait_cnt(1, 7);
        data8 = 8'hC4;
        valid[1] = 1'b1;
        @(negedge clk);
        valid[1] = 1'b0;
        capture(1, bits, pb);
        check("idle_frame8", bits, 32'h0000_00AA);
        check("pclk8_pattern", pb, 32'h0000_000F);
        check("no_underrun_unarmed8", {31'h0, dunder[1]}, 32'h0);
        capture(1, bits, pb);
        check("word_C4", bits, 32'h0000_0023);
        @(negedge clk);
        check("underrun8_after_C4", {31'h0, dunder[1]}, 32'h1);

        // Back-to-back stream on the 16-bit instance
        wait_cnt(0, 3);
        clr = 1'b1;
        begin
            int k = 0;
            int g = 0;
            data16 = stream[0];
            valid[0] = 1'b1;
            while (k < 3 && g < 200) begin
                @(negedge clk);
                clr = 1'b0;
                g++;
                if (m_acc[0]) begin
                    k++;
                    if (k < 3) data16 = stream[k];
                end
            end
            valid[0] = 1'b0;
            check("stream_accepts", k, 3);
        end
        capture(0, bits, pb);
        check("word_FFFF", bits, 32'h0000_FFFF);
        check("stream_no_underrun", {31'h0, dunder[0]}, 32'h0);

        // Reset mid-word with a word held
        wait_cnt(0, 3);
        data16 = 16'h1234;
        valid[0] = 1'b1;
        @(negedge clk);
        valid[0] = 1'b0;
        wait_cnt(0, 0);
        data16 = 16'hBEEF;
        valid[0] = 1'b1;
        @(negedge clk);
        valid[0] = 1'b0;
        wait_cnt(0, 7);
        check("held_before_reset", {31'h0, dready[0]}, 32'h0);
        #2 rst_i = 1'b0;
        #1;
        check("midrst_q16", {31'h0, dq[0]}, 32'h0);
        check("midrst_ready16", {31'h0, dready[0]}, 32'h1);
        check("midrst_frame16", {31'h0, dframe[0]}, 32'h1);
        check("midrst_pclk16", {31'h0, dpclk[0]}, 32'h1);
        @(negedge clk);
        rst_i = 1'b1;
        capture(0, bits, pb);
        check("after_midrst_frame_a", bits, 32'h0);
        capture(0, bits, pb);
        check("after_midrst_frame_b", bits, 32'h0);
        check("after_midrst_underrun", {31'h0, dunder[0]}, 32'h0);

        // Randomized traffic on both instances
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            valid[0] = ($urandom_range(0, 3) != 0);
            valid[1] = ($urandom_range(0, 2) == 0);
            data16 = 16'($urandom);
            data8 = 8'($urandom);
            clr = ($urandom_range(0, 15) == 0);
        end
        @(negedge clk);
        valid = 2'b00;
        clr = 1'b0;
        repeat (40) @(negedge clk);
        run = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/soft_oser16_tx.md
Name: soft_oser16_tx

Overview:
- Soft-logic 16:1 serializer. It is the transmit counterpart of the IDES16 deserializer examples.
- It accepts parallel words over a valid/ready handshake and shifts them out one bit per fast-clock cycle.
- It generates its own divided word clock (pclk_o) and a frame marker.
- It sits between user logic and a serial output pin. In board tests it loops back into an IDES16 receiver.

Parameters:
- WIDTH, 16, word length in bits; even, range 4..32.
- LSB_FIRST, 1, 1 = bit 0 is transmitted first; 0 = bit WIDTH-1 is transmitted first.
- IDLE_WORD, 16'h0000 (WIDTH bits), word transmitted when no data is pending.

Ports:
- clk, input, 1, fast serial bit clock; all logic is on its rising edge.
- rst_i, input, 1, asynchronous active-low reset.
- data_i, input, WIDTH, parallel word to transmit.
- valid_i, input, 1, data_i is valid.
- ready_o, output, 1, holding register is empty; a word is accepted when valid_i && ready_o.
- clr_underrun_i, input, 1, synchronous clear of underrun_o.
- q_o, output, 1, serial data out; registered.
- pclk_o, output, 1, word clock: high for bit slots 0..WIDTH/2-1, low for the rest; registered.
- frame_o, output, 1, high during bit slot 0 of every word; registered.
- underrun_o, output, 1, sticky: a frame boundary occurred with no word pending.

Behaviour:
- State:
  - bit counter cnt, $clog2(WIDTH) bits, counts 0..WIDTH-1 and wraps.
  - shift register sh, WIDTH bits.
  - holding register hold, WIDTH bits, with hold_full flag.
  - armed flag.
  - underrun flag.
- Reset (rst_i low, asynchronous):
  - cnt=0, sh=IDLE_WORD, hold_full=0, armed=0, underrun_o=0.
  - ready_o=1, pclk_o=1, frame_o=1.
  - q_o = first-transmitted bit of IDLE_WORD.
- Reset asserted mid-word aborts that word immediately. A held word is discarded.
- Output mapping: q_o = sh[0] if LSB_FIRST, else sh[WIDTH-1]. Outputs are registered, so no combinational path from inputs to q_o.
- Each cycle, cnt advances to cnt+1, wrapping WIDTH-1 -> 0.
- pclk_o next = (cnt_next < WIDTH/2); frame_o next = (cnt_next == 0).
- Non-boundary cycle (cnt != WIDTH-1): sh shifts by one toward the output end. LSB_FIRST shifts right, otherwise left. Fill bit is 0.
- Boundary cycle (cnt == WIDTH-1):
  - If hold_full: sh <= hold and hold_full clears.
  - Else: sh <= IDLE_WORD, and underrun sets if armed.
- Handshake:
  - ready_o = !hold_full, registered.
  - On accept, hold <= data_i, hold_full sets and armed sets.
  - data_i is ignored when ready_o=0.
- hold_full next = (hold_full && !boundary) || (valid_i && ready_o).
- Simultaneous events:
  - Accept and transfer in the same cycle cannot occur, because ready_o=0 whenever hold_full.
  - Accept on a boundary cycle with hold empty: the IDLE_WORD frame is sent. The new word is held and goes out in the following frame; no bypass.
- Latency: a word accepted with hold empty starts at the next cnt==0 slot. Its first bit appears on q_o in the cycle where frame_o=1.
- ready_o reasserts in the cycle after the boundary that moved hold into sh. Sustained throughput is one word per WIDTH cycles.
- underrun_o:
  - It stays set until clr_underrun_i=1.
  - If clear and set coincide, set wins.
  - No underrun is flagged before the first accepted word after reset, because armed=0.

Test Plan:
- Reset: hold rst_i low mid-stream with IDLE_WORD=16'h0000 -> immediately q_o=0, ready_o=1, pclk_o=1, frame_o=1, underrun_o=0. After release, 16 cycles of zeros with no underrun.
- Single word, LSB first: accept 16'hA5C3 at cycle 2 -> the frame starting at the next frame_o shows bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1. After that frame: IDLE, underrun_o=1; clr_underrun_i pulse -> underrun_o=0.
- Back-to-back: stream 16'h0001, 16'h8000, 16'hFFFF with valid_i held high -> three consecutive frames with no gap, no underrun. ready_o is low from each accept until the cycle after the boundary.
- Boundary accept: valid_i asserted exactly on a cnt==15 cycle with hold empty -> that frame is IDLE_WORD and the next frame carries the word. underrun_o is set only if a word had been accepted earlier.
- LSB_FIRST=0, WIDTH=8, IDLE_WORD=8'h55: send 8'hC4 -> q_o sequence 1,1,0,0,0,1,0,0. pclk_o is high for slots 0-3. Idle frames are 0,1,0,1,0,1,0,1.
- Reset mid-word: pull rst_i low at slot 7 with a word held -> q_o returns to the idle bit immediately. The held word is never transmitted and ready_o=1 after release.
